// File: rtl/ram_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the single RAM slave port.
// Grant is held for a whole cyc (bursts included); a watchdog errors out stalled accesses.
module ram_wb_arbiter #(
    parameter int DAT_W   = 32,
    parameter int ADR_W   = 10,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    input  logic             m0_we_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic [2:0]       m0_cti_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    input  logic             m1_we_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic [2:0]       m1_cti_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic             s_we_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic [2:0]       s_cti_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WD_W-1:0] WD_SAT  = '1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t          state_q;
    logic            last_q;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            g0, g1, gnt_cyc, gnt_stb, oth_cyc, timeout;

    assign g0      = (state_q == GNT0);
    assign g1      = (state_q == GNT1);
    assign gnt_cyc = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
    assign gnt_stb = (g0 & m0_stb_i) | (g1 & m1_stb_i);
    assign oth_cyc = g0 ? m1_cyc_i : m0_cyc_i;

    // An ack arriving in the final watchdog cycle still completes the access.
    assign timeout = (TIMEOUT != 0) && gnt_stb && !s_ack_i && (wdog_q == WD_LAST);

    always_comb begin
        wdog_d = '0;
        if (gnt_stb && !s_ack_i)
            wdog_d = (wdog_q == WD_SAT) ? wdog_q : wdog_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wdog_q <= '0;
                    if (m0_cyc_i && m1_cyc_i) state_q <= last_q ? GNT0 : GNT1;
                    else if (m0_cyc_i)        state_q <= GNT0;
                    else if (m1_cyc_i)        state_q <= GNT1;
                end
                default: begin
                    // Hand over directly to a waiting master without an IDLE gap.
                    if (!gnt_cyc || timeout) begin
                        last_q  <= g1;
                        wdog_q  <= '0;
                        state_q <= oth_cyc ? (g0 ? GNT1 : GNT0) : IDLE;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
            endcase
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (g0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_cti_o = m0_cti_i;
            s_cyc_o = m0_cyc_i & ~timeout;
            s_stb_o = m0_stb_i & ~timeout;
        end else if (g1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_cti_o = m1_cti_i;
            s_cyc_o = m1_cyc_i & ~timeout;
            s_stb_o = m1_stb_i & ~timeout;
        end
    end

    assign m0_dat_o = g0 ? s_dat_i : '0;
    assign m1_dat_o = g1 ? s_dat_i : '0;
    assign m0_ack_o = s_ack_i & g0 & m0_stb_i;
    assign m1_ack_o = s_ack_i & g1 & m1_stb_i;
    assign m0_err_o = timeout & g0;
    assign m1_err_o = timeout & g1;

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Directed bench for ram_wb_arbiter: scoreboard of expected acks/read data plus
// point checks of grant, burst, watchdog and reset behaviour.
module tb_ram_wb_arbiter;

    logic        clk, rst;
    logic [9:0]  m0_adr_i, m1_adr_i, s_adr_o;
    logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic        m0_we_i, m1_we_i, s_we_o;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic        m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, s_cyc_o, s_stb_o;
    logic [2:0]  m0_cti_i, m1_cti_i, s_cti_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_ack_i;

    ram_wb_arbiter #(.DAT_W(32), .ADR_W(10), .SEL_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple RAM behind the slave port; ack is driven by the bench directly.
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    assign s_dat_i = mem[s_adr_o];
    always @(posedge clk)
        if (s_cyc_o && s_stb_o && s_ack_i && s_we_o) mem[s_adr_o] <= s_dat_o;

    typedef struct { int m; bit we; logic [31:0] d; } exp_t;
    exp_t sb[$];
    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic collect(input string tag);
        exp_t e;
        n_asrt++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_ack"}, {30'd0, m1_ack_o, m0_ack_o}, (e.m != 0) ? 32'd2 : 32'd1);
            if (!e.we) chk({tag, "_rdat"}, (e.m != 0) ? m1_dat_o : m0_dat_o, e.d);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input int m, input bit cyc, input bit stb, input bit we,
                       input logic [9:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr;
            m0_dat_i = dat; m0_cti_i = cti; m0_sel_i = 4'hF;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr;
            m1_dat_i = dat; m1_cti_i = cti; m1_sel_i = 4'hF;
        end
    endtask

    task automatic idle(input int m);
        drv(m, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 3'b000);
    endtask

    task automatic wr(input int m, input logic [9:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        drv(m, 1'b1, 1'b1, 1'b1, adr, dat, cti);
        ref_mem[adr] = dat;
        sb.push_back('{m, 1'b1, dat});
    endtask

    task automatic rd(input int m, input logic [9:0] adr);
        drv(m, 1'b1, 1'b1, 1'b0, adr, 32'h0, 3'b000);
        sb.push_back('{m, 1'b0, ref_mem[adr]});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        s_ack_i = 1'b0;
        idle(0);
        idle(1);
        step(); step(); #1;
        chk("rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
        chk("rst_s_stb", {31'd0, s_stb_o}, 32'd0);
        chk("rst_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
        chk("rst_errs", {30'd0, m1_err_o, m0_err_o}, 32'd0);
        chk("rst_s_adr", {22'd0, s_adr_o}, 32'd0);
        chk("rst_m0_dat", m0_dat_o, 32'd0);
        rst = 1'b0;

        // T1: single write from m0
        step(); wr(0, 10'h004, 32'hDEADBEEF, 3'b000); #1;
        chk("t1_pre_gnt_cyc", {31'd0, s_cyc_o}, 32'd0);
        step(); #1;
        chk("t1_s_cyc", {31'd0, s_cyc_o}, 32'd1);
        chk("t1_s_adr", {22'd0, s_adr_o}, 32'h004);
        chk("t1_s_dat", s_dat_o, 32'hDEADBEEF);
        chk("t1_s_sel", {28'd0, s_sel_o}, 32'hF);
        chk("t1_s_we", {31'd0, s_we_o}, 32'd1);
        s_ack_i = 1'b1; #1;
        collect("t1");
        chk("t1_m1_ack", {31'd0, m1_ack_o}, 32'd0);
        step(); s_ack_i = 1'b0; idle(0); #1;
        chk("t1_ack_off", {31'd0, m0_ack_o}, 32'd0);
        step(); #1;
        chk("t1_idle_cyc", {31'd0, s_cyc_o}, 32'd0);

        // T2: tie after reset -> m0, handover without gap, round-robin
        rst = 1'b1; step(); rst = 1'b0;
        rd(0, 10'h004);
        wr(1, 10'h008, 32'h12345678, 3'b000);
        step(); #1;
        chk("t2_gnt0_we", {31'd0, s_we_o}, 32'd0);
        chk("t2_gnt0_adr", {22'd0, s_adr_o}, 32'h004);
        s_ack_i = 1'b1; #1; collect("t2_m0");
        step(); s_ack_i = 1'b0; idle(0);
        step(); #1;
        chk("t2_nogap_cyc", {31'd0, s_cyc_o}, 32'd1);
        chk("t2_gnt1_adr", {22'd0, s_adr_o}, 32'h008);
        s_ack_i = 1'b1; #1; collect("t2_m1");
        chk("t2_m0_noack", {31'd0, m0_ack_o}, 32'd0);
        step(); s_ack_i = 1'b0; idle(1);
        step(); rd(0, 10'h008); rd(1, 10'h004);
        step(); #1;
        chk("t2_rr_gnt0_adr", {22'd0, s_adr_o}, 32'h008);
        s_ack_i = 1'b1; #1; collect("t2_rr_m0");
        step(); s_ack_i = 1'b0; idle(0);
        step(); #1;
        chk("t2_rr_gnt1_adr", {22'd0, s_adr_o}, 32'h004);
        s_ack_i = 1'b1; #1; collect("t2_rr_m1");
        step(); s_ack_i = 1'b0; idle(1);
        step();

        // T3: m1 4-beat burst while m0 waits
        wr(1, 10'h010, 32'hA0, 3'b010);
        step(); drv(0, 1'b1, 1'b1, 1'b0, 10'h010, 32'h0, 3'b000);
        for (int b = 0; b < 4; b++) begin
            #1;
            chk("t3_beat_adr", {22'd0, s_adr_o}, 32'h010 + b);
            chk("t3_beat_cti", {29'd0, s_cti_o}, (b == 3) ? 32'd7 : 32'd2);
            s_ack_i = 1'b1; #1; collect("t3_beat");
            chk("t3_m0_wait", {31'd0, m0_ack_o}, 32'd0);
            step(); s_ack_i = 1'b0;
            if (b < 3) wr(1, 10'h011 + 10'(b), 32'hA1 + b, (b == 2) ? 3'b111 : 3'b010);
            else       drv(1, 1'b1, 1'b0, 1'b1, 10'h013, 32'hA3, 3'b111);
        end
        #1;
        chk("t3_hold_cyc", {31'd0, s_cyc_o}, 32'd1);
        chk("t3_hold_adr", {22'd0, s_adr_o}, 32'h013);
        idle(1);
        step();
        sb.push_back('{0, 1'b0, ref_mem[10'h010]});
        #1;
        chk("t3_m0_adr", {22'd0, s_adr_o}, 32'h010);
        chk("t3_m0_we", {31'd0, s_we_o}, 32'd0);
        s_ack_i = 1'b1; #1; collect("t3_m0");
        step(); s_ack_i = 1'b0; idle(0);
        step();

        // T4: watchdog fires on the 8th unacked strobe clock, m1 takes over
        drv(0, 1'b1, 1'b1, 1'b0, 10'h004, 32'h0, 3'b000);
        step(); rd(1, 10'h013);
        for (int i = 1; i < 8; i++) begin
            #1; chk("t4_no_err", {31'd0, m0_err_o}, 32'd0);
            step();
        end
        #1;
        chk("t4_err", {31'd0, m0_err_o}, 32'd1);
        chk("t4_cyc_forced", {31'd0, s_cyc_o}, 32'd0);
        chk("t4_stb_forced", {31'd0, s_stb_o}, 32'd0);
        chk("t4_m1_err", {31'd0, m1_err_o}, 32'd0);
        idle(0);
        step(); #1;
        chk("t4_err_1clk", {31'd0, m0_err_o}, 32'd0);
        chk("t4_m1_adr", {22'd0, s_adr_o}, 32'h013);
        s_ack_i = 1'b1; #1; collect("t4_m1");
        step(); s_ack_i = 1'b0; idle(1);
        step();

        // T5: reset during m1 burst beat 2
        wr(1, 10'h020, 32'hB0, 3'b010);
        step(); s_ack_i = 1'b1; #1; collect("t5_b0");
        step(); s_ack_i = 1'b0; wr(1, 10'h021, 32'hB1, 3'b010);
        s_ack_i = 1'b1; #1; collect("t5_b1");
        step(); s_ack_i = 1'b0;
        drv(1, 1'b1, 1'b1, 1'b1, 10'h022, 32'hB2, 3'b010);
        s_ack_i = 1'b1; #1;
        chk("t5_pre_ack", {31'd0, m1_ack_o}, 32'd1);
        rst = 1'b1; #1;
        chk("t5_rst_cyc", {31'd0, s_cyc_o}, 32'd0);
        chk("t5_rst_ack", {31'd0, m1_ack_o}, 32'd0);
        s_ack_i = 1'b0; idle(1);
        step(); rst = 1'b0;
        rd(0, 10'h020); rd(1, 10'h021);
        step(); #1;
        chk("t5_tie_m0_adr", {22'd0, s_adr_o}, 32'h020);
        s_ack_i = 1'b1; #1; collect("t5_m0");
        step(); s_ack_i = 1'b0; idle(0);
        step(); #1;
        chk("t5_m1_adr", {22'd0, s_adr_o}, 32'h021);
        s_ack_i = 1'b1; #1; collect("t5_m1");
        step(); s_ack_i = 1'b0; idle(1);
        step();

        // T6: ack in the final watchdog clock wins; watchdog restarts after it
        rd(0, 10'h008);
        step();
        for (int i = 1; i < 8; i++) begin
            #1; chk("t6_no_err", {31'd0, m0_err_o}, 32'd0);
            step();
        end
        s_ack_i = 1'b1; #1;
        chk("t6_ack_wins_err", {31'd0, m0_err_o}, 32'd0);
        chk("t6_ack_wins_cyc", {31'd0, s_cyc_o}, 32'd1);
        collect("t6_m0");
        step(); s_ack_i = 1'b0;
        drv(0, 1'b1, 1'b1, 1'b0, 10'h004, 32'h0, 3'b000);
        for (int i = 1; i < 8; i++) begin
            #1; chk("t6_wdog_cleared", {31'd0, m0_err_o}, 32'd0);
            step();
        end
        #1;
        chk("t6_wdog_rearm", {31'd0, m0_err_o}, 32'd1);
        idle(0);
        step(); step();

        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
